// File: rtl/llsc_mem_ctrl_pkg.sv
// Shared opcodes, bus widths and state encoding for the MEM-stage LL/SC
// data-memory access controller.
package llsc_mem_ctrl_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;

  localparam logic [7:0] EXE_LW_OP = 8'b1110_0011;
  localparam logic [7:0] EXE_SW_OP = 8'b1110_1011;
  localparam logic [7:0] EXE_LL_OP = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP = 8'b1111_1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SW_OP) || (op == EXE_SC_OP);
  endfunction

endpackage

// File: rtl/llsc_link_tracker.sv
// Holds the LL link (word address + valid) and snoops foreign stores against it;
// a snoop hit is turned into a one-cycle-delayed LLbit clear request.
module llsc_link_tracker
  import llsc_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [BUS_AW-3:0] set_addr_i,
  input  logic              clr_i,
  input  logic              snoop_we_i,
  input  logic [BUS_AW-1:0] snoop_addr_i,
  output logic              link_valid_o,
  output logic              hit_o,
  output logic              snoop_pend_o
);

  logic [BUS_AW-3:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              pend_q;
  logic              unused_snoop_lsb;

  assign unused_snoop_lsb = ^snoop_addr_i[1:0];

  assign hit_o        = snoop_we_i && valid_q && (snoop_addr_i[BUS_AW-1:2] == addr_q);
  assign link_valid_o = valid_q;
  assign snoop_pend_o = pend_q;

  // A new link from an LL completing this cycle overrides any clear.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (hit_o || clr_i) valid_d = 1'b0;
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = set_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
      pend_q  <= hit_o;
    end
  end

endmodule

// File: rtl/llsc_mem_ctrl.sv
// MEM-stage controller for LW/SW/LL/SC over a req/ack bus; decides SC commit
// from the (forwarded) LLbit and issues LLbit set/clear requests toward WB.
module llsc_mem_ctrl
  import llsc_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_req_i,
  input  logic [7:0]        aluop_i,
  input  logic [BUS_AW-1:0] addr_i,
  input  logic [BUS_DW-1:0] wdata_i,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we_i,
  input  logic              wb_LLbit_value_i,
  input  logic              snoop_we_i,
  input  logic [BUS_AW-1:0] snoop_addr_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [BUS_AW-1:0] bus_addr_o,
  output logic [BUS_DW-1:0] bus_data_o,
  output logic [3:0]        bus_sel_o,
  input  logic              bus_ack_i,
  input  logic [BUS_DW-1:0] bus_data_i,
  output logic [BUS_DW-1:0] rdata_o,
  output logic              done_o,
  output logic              stallreq_o,
  output logic              LLbit_we_o,
  output logic              LLbit_value_o
);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic              we_q, we_d;
  logic              commit_q, commit_d;
  logic [BUS_AW-1:0] addr_q, addr_d;
  logic [BUS_DW-1:0] data_q, data_d;
  logic [BUS_DW-1:0] rdata_q, rdata_d;

  logic snoop_hit, snoop_pend, link_valid;
  logic eff_llbit, ll_done, sc_done;
  logic unused_link_valid;

  assign unused_link_valid = link_valid;

  assign eff_llbit = (wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i) && !snoop_hit;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    we_d     = we_q;
    commit_d = commit_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush && mem_req_i) begin
          op_d     = aluop_i;
          commit_d = 1'b0;
          if ((aluop_i == EXE_SC_OP) && !eff_llbit) begin
            state_d = ST_DONE;
            rdata_d = '0;
          end else begin
            state_d = ST_ACCESS;
            addr_d  = {addr_i[BUS_AW-1:2], 2'b00};
            data_d  = wdata_i;
            we_d    = is_store(aluop_i);
          end
        end
      end
      ST_ACCESS: begin
        // A write acked in the flush cycle has already completed; no drain needed.
        if (flush) begin
          state_d = (we_q && !bus_ack_i) ? ST_DRAIN : ST_IDLE;
        end else if (bus_ack_i) begin
          state_d = ST_DONE;
          if ((op_q == EXE_LW_OP) || (op_q == EXE_LL_OP)) begin
            rdata_d = bus_data_i;
          end else if (op_q == EXE_SC_OP) begin
            rdata_d  = {{(BUS_DW-1){1'b0}}, 1'b1};
            commit_d = 1'b1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_DRAIN: if (bus_ack_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      we_q     <= 1'b0;
      commit_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      we_q     <= we_d;
      commit_q <= commit_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus_req_o  = (state_q == ST_ACCESS) || (state_q == ST_DRAIN);
  assign bus_we_o   = bus_req_o && we_q;
  assign bus_sel_o  = bus_req_o ? 4'b1111 : 4'b0000;
  assign bus_addr_o = addr_q;
  assign bus_data_o = data_q;
  assign rdata_o    = rdata_q;

  assign done_o     = (state_q == ST_DONE) && !flush;
  assign stallreq_o = ((state_q == ST_IDLE) && mem_req_i) || bus_req_o;

  assign ll_done = done_o && (op_q == EXE_LL_OP);
  assign sc_done = done_o && (op_q == EXE_SC_OP) && commit_q;

  assign LLbit_we_o    = ll_done || sc_done || snoop_pend;
  assign LLbit_value_o = ll_done;

  llsc_link_tracker u_link (
    .clk          (clk),
    .rst_n        (rst),
    .set_i        (ll_done),
    .set_addr_i   (addr_i[BUS_AW-1:2]),
    .clr_i        (sc_done || flush),
    .snoop_we_i   (snoop_we_i),
    .snoop_addr_i (snoop_addr_i),
    .link_valid_o (link_valid),
    .hit_o        (snoop_hit),
    .snoop_pend_o (snoop_pend)
  );

endmodule

// File: tb/tb_llsc_mem_ctrl.sv
// Directed bench for llsc_mem_ctrl: LL/SC commit and failure, snoop clear,
// flush of reads and writes, stray ack and asynchronous reset.
module tb_llsc_mem_ctrl;
  import llsc_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_req_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i, wdata_i;
  logic        LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i;
  logic        snoop_we_i;
  logic [31:0] snoop_addr_i;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_data_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack_i;
  logic [31:0] bus_data_i;
  logic [31:0] rdata_o;
  logic        done_o, stallreq_o, LLbit_we_o, LLbit_value_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  llsc_mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .mem_req_i        (mem_req_i),
    .aluop_i          (aluop_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .LLbit_i          (LLbit_i),
    .wb_LLbit_we_i    (wb_LLbit_we_i),
    .wb_LLbit_value_i (wb_LLbit_value_i),
    .snoop_we_i       (snoop_we_i),
    .snoop_addr_i     (snoop_addr_i),
    .bus_req_o        (bus_req_o),
    .bus_we_o         (bus_we_o),
    .bus_addr_o       (bus_addr_o),
    .bus_data_o       (bus_data_o),
    .bus_sel_o        (bus_sel_o),
    .bus_ack_i        (bus_ack_i),
    .bus_data_i       (bus_data_i),
    .rdata_o          (rdata_o),
    .done_o           (done_o),
    .stallreq_o       (stallreq_o),
    .LLbit_we_o       (LLbit_we_o),
    .LLbit_value_o    (LLbit_value_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    mem_req_i = 1'b1;
    aluop_i   = op;
    addr_i    = a;
    wdata_i   = d;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; mem_req_i = 1'b0; aluop_i = '0;
    addr_i = '0; wdata_i = '0; LLbit_i = 1'b0;
    wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
    snoop_we_i = 1'b0; snoop_addr_i = '0;
    bus_ack_i = 1'b0; bus_data_i = '0;

    // reset state
    smp();
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_bus_sel", bus_sel_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_stall", stallreq_o, 0);
    chk("rst_llwe", LLbit_we_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    tick(); rst = 1'b1;
    tick();

    // LL 0x100, ack after two wait cycles
    req(EXE_LL_OP, 32'h100, 32'h0);
    smp();
    chk("ll_idle_stall", stallreq_o, 1);
    chk("ll_idle_req", bus_req_o, 0);
    tick(); smp();
    chk("ll_acc_req", bus_req_o, 1);
    chk("ll_acc_addr", bus_addr_o, 32'h100);
    chk("ll_acc_we", bus_we_o, 0);
    chk("ll_acc_sel", bus_sel_o, 4'hF);
    tick(); smp();
    chk("ll_wait1_done", done_o, 0);
    tick(); smp();
    chk("ll_wait2_req", bus_req_o, 1);
    tick(); bus_ack_i = 1'b1; bus_data_i = 32'hDEADBEEF;
    smp();
    chk("ll_ack_done", done_o, 0);
    tick(); bus_ack_i = 1'b0; bus_data_i = '0;
    smp();
    chk("ll_done", done_o, 1);
    chk("ll_rdata", rdata_o, 32'hDEADBEEF);
    chk("ll_llwe", LLbit_we_o, 1);
    chk("ll_llval", LLbit_value_o, 1);
    chk("ll_done_stall", stallreq_o, 0);
    chk("ll_done_req", bus_req_o, 0);

    // SC 0x100 data 5 with LLbit set: commits
    tick(); LLbit_i = 1'b1;
    req(EXE_SC_OP, 32'h100, 32'h5);
    smp();
    chk("sc_idle_done", done_o, 0);
    chk("sc_idle_llwe", LLbit_we_o, 0);
    tick(); bus_ack_i = 1'b1;
    smp();
    chk("sc_acc_req", bus_req_o, 1);
    chk("sc_acc_we", bus_we_o, 1);
    chk("sc_acc_data", bus_data_o, 32'h5);
    chk("sc_acc_addr", bus_addr_o, 32'h100);
    tick(); bus_ack_i = 1'b0;
    smp();
    chk("sc_done", done_o, 1);
    chk("sc_rdata", rdata_o, 1);
    chk("sc_llwe", LLbit_we_o, 1);
    chk("sc_llval", LLbit_value_o, 0);

    // SC failing through WB forward of LLbit=0
    tick(); LLbit_i = 1'b1; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b0;
    req(EXE_SC_OP, 32'h200, 32'h7);
    smp();
    chk("scf_stall", stallreq_o, 1);
    tick(); wb_LLbit_we_i = 1'b0;
    smp();
    chk("scf_done", done_o, 1);
    chk("scf_req", bus_req_o, 0);
    chk("scf_rdata", rdata_o, 0);
    chk("scf_llwe", LLbit_we_o, 0);

    // LL 0x100 zero-wait, then snoop store at 0x103 clears the link
    tick(); LLbit_i = 1'b0;
    req(EXE_LL_OP, 32'h100, 32'h0);
    tick(); bus_ack_i = 1'b1; bus_data_i = 32'h12345678;
    tick(); bus_ack_i = 1'b0; bus_data_i = '0;
    smp();
    chk("ll2_done", done_o, 1);
    chk("ll2_rdata", rdata_o, 32'h12345678);
    tick(); mem_req_i = 1'b0; LLbit_i = 1'b1;
    snoop_we_i = 1'b1; snoop_addr_i = 32'h103;
    smp();
    chk("snp_same_llwe", LLbit_we_o, 0);
    tick(); snoop_we_i = 1'b0; snoop_addr_i = '0;
    smp();
    chk("snp_llwe", LLbit_we_o, 1);
    chk("snp_llval", LLbit_value_o, 0);
    tick(); LLbit_i = 1'b0;
    smp();
    chk("snp_after_llwe", LLbit_we_o, 0);
    req(EXE_SC_OP, 32'h100, 32'h9);
    tick(); smp();
    chk("snp_sc_done", done_o, 1);
    chk("snp_sc_rdata", rdata_o, 0);
    chk("snp_sc_req", bus_req_o, 0);

    // flush during SW access: drain until ack, no done
    tick(); req(EXE_SW_OP, 32'h300, 32'hAA55);
    tick(); flush = 1'b1;
    smp();
    chk("sw_acc_we", bus_we_o, 1);
    tick(); flush = 1'b0; mem_req_i = 1'b0;
    smp();
    chk("drain_req", bus_req_o, 1);
    chk("drain_we", bus_we_o, 1);
    chk("drain_stall", stallreq_o, 1);
    chk("drain_done", done_o, 0);
    tick(); bus_ack_i = 1'b1;
    smp();
    chk("drain_ack_req", bus_req_o, 1);
    tick(); bus_ack_i = 1'b0;
    smp();
    chk("drain_end_req", bus_req_o, 0);
    chk("drain_end_done", done_o, 0);
    chk("drain_end_stall", stallreq_o, 0);

    // flush during LW access: request drops next cycle
    tick(); req(EXE_LW_OP, 32'h400, 32'h0);
    tick(); flush = 1'b1;
    smp();
    chk("lwf_acc_req", bus_req_o, 1);
    tick(); flush = 1'b0; mem_req_i = 1'b0;
    smp();
    chk("lwf_req", bus_req_o, 0);
    chk("lwf_done", done_o, 0);
    chk("lwf_rdata", rdata_o, 0);

    // stray ack in IDLE is ignored
    tick(); bus_ack_i = 1'b1; bus_data_i = 32'h55555555;
    tick(); bus_ack_i = 1'b0; bus_data_i = '0;
    smp();
    chk("stray_done", done_o, 0);
    chk("stray_rdata", rdata_o, 0);

    // reset asserted mid-access
    tick(); req(EXE_LW_OP, 32'h500, 32'h0);
    tick(); smp();
    chk("rsta_req", bus_req_o, 1);
    chk("rsta_addr", bus_addr_o, 32'h500);
    rst = 1'b0; mem_req_i = 1'b0;
    #1;
    chk("rsta0_req", bus_req_o, 0);
    chk("rsta0_sel", bus_sel_o, 0);
    chk("rsta0_addr", bus_addr_o, 0);
    chk("rsta0_stall", stallreq_o, 0);
    tick(); rst = 1'b1;
    smp();
    chk("rstr_req", bus_req_o, 0);

    // normal LW after reset, zero-wait
    tick(); req(EXE_LW_OP, 32'h504, 32'h0);
    tick(); bus_ack_i = 1'b1; bus_data_i = 32'hCAFEF00D;
    smp();
    chk("lw_addr", bus_addr_o, 32'h504);
    tick(); bus_ack_i = 1'b0; bus_data_i = '0;
    smp();
    chk("lw_done", done_o, 1);
    chk("lw_rdata", rdata_o, 32'hCAFEF00D);
    chk("lw_llwe", LLbit_we_o, 0);
    tick(); mem_req_i = 1'b0;
    smp();
    chk("lw_after_done", done_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/llsc_mem_ctrl.md
# llsc_mem_ctrl

MEM-stage data-memory access controller for the OpenMIPS pipeline; the consumer side of the LL/SC link mechanism. It executes LW/SW/LL/SC word accesses over a single-master request/acknowledge bus and reads the LLbit (with WB-stage forwarding) to decide whether an SC commits. It produces LLbit write requests (set on LL, clear on SC and on a snooped conflicting store) that travel to the LLbit register, and it stalls the pipeline while a bus access is outstanding.

## Interface
Parameters:
- none; opcodes `EXE_LW_OP`, `EXE_SW_OP`, `EXE_LL_OP`, `EXE_SC_OP` come from defines.v.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- flush  in  1  exception flush, synchronous
- mem_req_i  in  1  MEM-stage instruction is a memory op
- aluop_i  in  8  op code (one of the four above)
- addr_i  in  32  word address; bits [1:0] ignored
- wdata_i  in  32  store data
- LLbit_i  in  1  current LLbit register value
- wb_LLbit_we_i / wb_LLbit_value_i  in  1/1  WB-stage pending LLbit write (forward)
- snoop_we_i / snoop_addr_i  in  1/32  store by another master
- bus_req_o, bus_we_o  out  1/1  bus request, write
- bus_addr_o, bus_data_o  out  32/32  address (bits [1:0]=0), write data
- bus_sel_o  out  4  always 4'b1111 while bus_req_o
- bus_ack_i, bus_data_i  in  1/32  acknowledge, read data
- rdata_o  out  32  load data, or SC result (1 commit / 0 fail)
- done_o  out  1  one-cycle completion pulse
- stallreq_o  out  1  pipeline stall request
- LLbit_we_o, LLbit_value_o  out  1/1  LLbit write request toward WB

## Operation
- States: IDLE, ACCESS, DONE, DRAIN.
- Effective LLbit: eff = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i; a snoop hit in the same cycle forces eff = 0.
- IDLE + mem_req_i: SC with eff=0 -> DONE, no bus access, rdata_o=0. Otherwise -> ACCESS; bus_addr_o/bus_data_o/bus_we_o (1 for SW, SC) registered.
- ACCESS: bus_req_o=1 held with stable fields until bus_ack_i; on ack -> DONE, rdata_o = bus_data_i (LW, LL) or 1 (SC) or unchanged (SW).
- DONE: done_o=1; LL -> LLbit_we_o=1, value 1, link_addr <= addr_i[31:2], link_valid=1; committed SC -> LLbit_we_o=1, value 0, link_valid=0. Always -> IDLE.
- Snoop: snoop_we_i && link_valid && snoop_addr_i[31:2]==link_addr -> link_valid=0, LLbit_we_o=1/value 0 next cycle unless DONE of an LL drives it (LL wins).
- flush: IDLE/DONE/ACCESS-read -> IDLE, bus_req_o dropped, no done_o, no LLbit write, link_valid=0. ACCESS-write -> DRAIN: hold bus_req_o until ack, then IDLE, no done_o.
- stallreq_o = (IDLE && mem_req_i) || ACCESS || DRAIN; 0 in DONE.

## Timing
- Reset: state IDLE; bus_req_o, bus_we_o, done_o, stallreq_o, LLbit_we_o, LLbit_value_o, link_valid = 0; bus_addr_o, bus_data_o, rdata_o = 0; bus_sel_o = 0.
- Request sampled at edge T: bus_req_o high T+1; ack at cycle T+k -> done_o at T+k+1, pipeline advances at end of that cycle. Minimum 3 cycles with zero-wait ack.
- Failed SC: done_o at T+1, no bus cycle.
- Ack only honoured in ACCESS/DRAIN; stray ack ignored.
- mem_req_i must stay asserted with stable fields while stallreq_o=1.

## Structure
- Opcodes and state encodings in defines.v (shared); bus width constants there too.
- No sub-module; optional link tracker (link_addr, link_valid, snoop compare) as llsc_link_tracker.

## Test plan
- LL 0x100 ack after 2 wait cycles returns 0xDEADBEEF -> done_o with rdata_o=0xDEADBEEF, LLbit_we_o=1/value 1.
- LL 0x100 then SC 0x100 data 0x5 with LLbit_i=1 -> bus write 0x5 @0x100, rdata_o=1, LLbit_we_o=1/value 0.
- SC with LLbit_i=1 but wb_LLbit_we_i=1/value 0 -> no bus_req_o, rdata_o=0, done_o at T+1.
- LL 0x100, snoop_we_i @0x103 -> LLbit_we_o=1/value 0 next cycle; following SC fails rdata_o=0.
- flush during ACCESS for SW -> bus_req_o held until ack, no done_o; flush during LW ACCESS -> bus_req_o drops next cycle.
- rst low mid-ACCESS -> all outputs 0 immediately, state IDLE after release.
